// File: rtl/sap_out_display_if.sv
// CPU output-port bundle: load strobe and value in, conversion status and display drive out.
interface sap_out_display_if;
    logic        lo;
    logic [7:0]  out_bus;
    logic        busy;
    logic        valid;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (
        output lo, out_bus,
        input  busy, valid, bcd, seg, an
    );

    modport slave (
        input  lo, out_bus,
        output busy, valid, bcd, seg, an
    );
endinterface

// File: rtl/sap_out_display.sv
// SAP output register -> 8-iteration double-dabble BCD -> multiplexed 3-digit 7-segment display.
// Result lands 8 edges after capture; no backpressure, one pending slot absorbs OUTs during conversion (latest wins).
module sap_out_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    sap_out_display_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state;
    logic [7:0]  shift_q;
    logic [11:0] scratch_q;
    logic [2:0]  iter_q;
    logic        pend_vld;
    logic [7:0]  pend_dat;
    logic        busy_q;
    logic        valid_q;
    logic [11:0] bcd_q;
    logic [CW-1:0] scan_cnt;
    logic [2:0]  an_q;
    logic [6:0]  seg_q;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [11:0] scr_adj;
    logic [11:0] scr_next;
    logic [7:0]  shift_next;

    always_comb begin
        scr_adj    = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};
        scr_next   = {scr_adj[10:0], shift_q[7]};
        shift_next = {shift_q[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            pend_vld  <= 1'b0;
            pend_dat  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            bcd_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.lo) begin
                        shift_q   <= bus.out_bus;
                        scratch_q <= '0;
                        iter_q    <= '0;
                        state     <= CONV;
                        busy_q    <= 1'b1;
                    end
                end
                CONV: begin
                    if (iter_q == 3'd7) begin
                        bcd_q   <= scr_next;
                        valid_q <= 1'b1;
                        // A fresh strobe beats the pending value, which is then dropped.
                        if (bus.lo) begin
                            shift_q   <= bus.out_bus;
                            scratch_q <= '0;
                            iter_q    <= '0;
                            pend_vld  <= 1'b0;
                        end else if (pend_vld) begin
                            shift_q   <= pend_dat;
                            scratch_q <= '0;
                            iter_q    <= '0;
                            pend_vld  <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        scratch_q <= scr_next;
                        shift_q   <= shift_next;
                        iter_q    <= iter_q + 3'd1;
                        if (bus.lo) begin
                            pend_vld <= 1'b1;
                            pend_dat <= bus.out_bus;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [2:0] an_next;
    logic [3:0] digit;
    logic       blank;

    always_comb begin
        an_next = {an_q[1:0], an_q[2]};
        case (an_next)
            3'b100: begin
                digit = bcd_q[11:8];
                blank = !valid_q || (bcd_q[11:8] == 4'd0);
            end
            3'b010: begin
                digit = bcd_q[7:4];
                blank = !valid_q || (bcd_q[11:4] == 8'd0);
            end
            default: begin
                digit = bcd_q[3:0];
                blank = !valid_q;
            end
        endcase
    end

    // seg moves only together with an, so it always matches the enabled digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            an_q     <= 3'b001;
            seg_q    <= 7'h00;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            an_q     <= an_next;
            seg_q    <= blank ? 7'h00 : seg_decode(digit);
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.bcd   = bcd_q;
    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
endmodule
